// File: rtl/spr_pkg.sv
// Shared types and defaults for the SPR core timing controller.
package spr_pkg;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2,
    S_LINE  = 2'd3
  } spr_state_e;

  localparam int XW_DEF       = 12;
  localparam int YW_DEF       = 12;
  localparam int CORE_LAT_DEF = 2;
  localparam int H_MAX_DEF    = 4095;
  localparam int SYNC_W       = 3;

endpackage

// File: rtl/spr_sync_delay.sv
// Fixed-depth shift register that carries the sync bundle alongside the core pipeline.
module spr_sync_delay
  import spr_pkg::*;
#(
  parameter int W     = SYNC_W,
  parameter int DEPTH = CORE_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/spr_core_ctrl.sv
// Timing/sequencing controller for the SPR cores: frame FSM, config shadowing,
// pixel/line counters, line-width checks and latency-matched output sync.
module spr_core_ctrl
  import spr_pkg::*;
#(
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int CORE_LAT = CORE_LAT_DEF,
  parameter int H_MAX    = H_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          cfg_sep_case,
  input  logic          cfg_core_en,
  input  logic          err_clr,
  output logic          spr_sep_case,
  output logic          core_en,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic          frame_done,
  output logic [YW-1:0] lines_last,
  output logic          err_hlong,
  output logic          err_width
);

  localparam logic [XW-1:0] H_LAST = XW'(H_MAX - 1);

  spr_state_e    state_q, state_d;
  logic          sep_q, sep_d, en_q, en_d;
  logic [XW-1:0] x_q, x_d, x_cur, line_len, ref_q, ref_d;
  logic          ref_vld_q, ref_vld_d;
  logic [YW-1:0] y_q, y_d, lines_q, lines_d;
  logic          done_q, done_d, err_h_q, err_h_d, err_w_q, err_w_d, width_set;
  logic          leave_idle, in_frame, pix_act, line_end, frame_end, shadow_en;
  logic [SYNC_W-1:0] sync_in, sync_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_SYNC;
    else        state_q <= state_d;
  end

  // Loss of i_vs always wins over i_hs activity.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:  if (!i_vs) state_d = S_IDLE;
      S_IDLE:  if (i_vs) state_d = i_hs ? S_LINE : S_FRAME;
      S_FRAME: if (!i_vs) state_d = S_IDLE; else if (i_hs) state_d = S_LINE;
      S_LINE:  if (!i_vs) state_d = S_IDLE; else if (!i_hs) state_d = S_FRAME;
      default: state_d = S_SYNC;
    endcase
  end

  // On the frame-start cycle the live cfg is used so the first pixel already sees it.
  always_comb begin
    leave_idle   = (state_q == S_IDLE) && (state_d != S_IDLE);
    in_frame     = (state_q == S_FRAME) || (state_q == S_LINE);
    pix_act      = (state_d == S_LINE);
    line_end     = (state_q == S_LINE) && (state_d != S_LINE);
    frame_end    = in_frame && (state_d == S_IDLE);
    shadow_en    = leave_idle ? cfg_core_en  : en_q;
    spr_sep_case = leave_idle ? cfg_sep_case : sep_q;
    core_en      = i_hs & i_vs & shadow_en & pix_act;
  end

  always_comb begin
    x_cur = '0;
    if (state_q == S_LINE) x_cur = (x_q == H_LAST) ? x_q : x_q + XW'(1);
    x_cnt    = pix_act ? x_cur : x_q;
    line_len = x_q + XW'(1);
  end

  always_comb begin
    x_d       = pix_act ? x_cur : x_q;
    sep_d     = spr_sep_case;
    en_d      = shadow_en;
    y_d       = y_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    width_set = 1'b0;
    if (line_end) begin
      y_d = y_q + YW'(1);
      if (!ref_vld_q) begin
        ref_d     = line_len;
        ref_vld_d = 1'b1;
      end else if (line_len != ref_q) begin
        width_set = 1'b1;
      end
    end
    if (leave_idle || frame_end) begin
      y_d       = '0;
      ref_vld_d = 1'b0;
    end
    done_d  = frame_end;
    lines_d = frame_end ? (y_q + YW'(line_end)) : lines_q;
    err_h_d = (pix_act && (x_cur == H_LAST)) | (err_h_q & ~err_clr);
    err_w_d = width_set | (err_w_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      sep_q     <= 1'b0;
      en_q      <= 1'b0;
      lines_q   <= '0;
      done_q    <= 1'b0;
      err_h_q   <= 1'b0;
      err_w_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      sep_q     <= sep_d;
      en_q      <= en_d;
      lines_q   <= lines_d;
      done_q    <= done_d;
      err_h_q   <= err_h_d;
      err_w_q   <= err_w_d;
    end
  end

  assign y_cnt      = y_q;
  assign lines_last = lines_q;
  assign frame_done = done_q;
  assign err_hlong  = err_h_q;
  assign err_width  = err_w_q;

  assign sync_in = {i_hs, i_vs, i_hs & i_vs};

  spr_sync_delay #(
    .W     (SYNC_W),
    .DEPTH (CORE_LAT)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_in),
    .q_o   (sync_out)
  );

  assign {o_hs, o_vs, o_de} = sync_out;

endmodule

// File: tb/tb_spr_core_ctrl.sv
// Randomized frame-level bench for spr_core_ctrl with a queue-based scoreboard.
module tb_spr_core_ctrl;

  localparam int XW       = 12;
  localparam int YW       = 12;
  localparam int CORE_LAT = 2;
  localparam int H_MAX    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_hs = 1'b0, i_vs = 1'b0;
  logic          cfg_sep_case = 1'b0, cfg_core_en = 1'b0, err_clr = 1'b0;
  logic          spr_sep_case, core_en, o_hs, o_vs, o_de, frame_done, err_hlong, err_width;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt, lines_last;

  spr_core_ctrl #(
    .XW(XW), .YW(YW), .CORE_LAT(CORE_LAT), .H_MAX(H_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs),
    .cfg_sep_case(cfg_sep_case), .cfg_core_en(cfg_core_en), .err_clr(err_clr),
    .spr_sep_case(spr_sep_case), .core_en(core_en), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .frame_done(frame_done),
    .lines_last(lines_last), .err_hlong(err_hlong), .err_width(err_width)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit sep;
  } pix_t;

  pix_t        pix_q[$];
  int          frame_q[$];
  logic [2:0]  dl_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          m_err_w = 1'b0;
  bit          m_err_h = 1'b0;
  logic [2:0]  mon_exp;
  pix_t        mon_p;
  int          mon_f;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    dl_q.delete();
    for (int i = 0; i < CORE_LAT; i++) dl_q.push_back(3'b000);
    m_err_w = 1'b0;
    m_err_h = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or a frame_done.
  always @(negedge clk) begin
    if (rst_n) begin
      dl_q.push_back({i_hs, i_vs, i_hs & i_vs});
      mon_exp = dl_q.pop_front();
      check("sync_delay", int'({o_hs, o_vs, o_de}), int'(mon_exp));
      if (core_en) begin
        if (pix_q.size() == 0) check("core_en_spurious", int'(core_en), 0);
        else begin
          mon_p = pix_q.pop_front();
          check("x_cnt", int'(x_cnt), mon_p.x);
          check("y_cnt", int'(y_cnt), mon_p.y);
          check("spr_sep_case", int'(spr_sep_case), int'(mon_p.sep));
        end
      end
      if (frame_done) begin
        if (frame_q.size() == 0) check("frame_done_spurious", int'(frame_done), 0);
        else begin
          mon_f = frame_q.pop_front();
          check("lines_last", int'(lines_last), mon_f);
        end
      end
    end
  end

  task automatic cyc(input logic hs, input logic vs);
    i_hs = hs;
    i_vs = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cfg();
    cfg_sep_case = 1'($urandom % 2);
    cfg_core_en  = 1'($urandom % 2);
  endtask

  function automatic int sat_len(input int w);
    return (w < H_MAX) ? w : H_MAX;
  endfunction

  task automatic check_errs();
    check("err_width", int'(err_width), int'(m_err_w));
    check("err_hlong", int'(err_hlong), int'(m_err_h));
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    m_err_w = 1'b0;
    m_err_h = 1'b0;
    check_errs();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x_cnt"}, int'(x_cnt), 0);
    check({tag, "_y_cnt"}, int'(y_cnt), 0);
    check({tag, "_core_en"}, int'(core_en), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_lines_last"}, int'(lines_last), 0);
    check({tag, "_err_width"}, int'(err_width), 0);
    check({tag, "_err_hlong"}, int'(err_hlong), 0);
    check({tag, "_o_sync"}, int'({o_hs, o_vs, o_de}), 0);
    check({tag, "_spr_sep_case"}, int'(spr_sep_case), 0);
  endtask

  // One frame described by its line widths; expectations come from the widths alone.
  task automatic run_frame(input int widths[$], input int front, input bit together,
                           input bit sep, input bit en, input int clr_at);
    int   n;
    int   ref_w;
    pix_t p;
    n     = widths.size();
    ref_w = sat_len(widths[0]);
    cfg_sep_case = sep;
    cfg_core_en  = en;
    for (int f = 0; f < front; f++) begin
      cyc(1'b0, 1'b1);
      rand_cfg();
    end
    for (int l = 0; l < n; l++) begin
      for (int i = 0; i < widths[l]; i++) begin
        if (en) begin
          p.x   = (i < H_MAX) ? i : H_MAX - 1;
          p.y   = l;
          p.sep = sep;
          pix_q.push_back(p);
        end
        err_clr = (l == 0 && i == clr_at);
        cyc(1'b1, 1'b1);
        err_clr = 1'b0;
        rand_cfg();
      end
      if (widths[l] >= H_MAX) m_err_h = 1'b1;
      if (sat_len(widths[l]) != ref_w) m_err_w = 1'b1;
      if (!(l == n - 1 && together)) begin
        repeat (1 + $urandom % 3) begin
          cyc(1'b0, 1'b1);
          rand_cfg();
        end
      end
    end
    frame_q.push_back(n);
    cyc(1'b0, 1'b0);
    repeat (2 + $urandom % 3) cyc(1'b0, 1'b0);
    check_errs();
  endtask

  initial begin
    int ws[$];
    int nl, base, w;

    model_reset();
    rst_n = 1'b0;
    i_vs = 1'b1;
    i_hs = 1'b1;
    cfg_sep_case = 1'b1;
    cfg_core_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    // i_vs held high out of reset: the half-seen frame must be ignored.
    for (int k = 0; k < 12; k++) cyc(1'((k % 6) < 4), 1'b1);
    repeat (3) cyc(1'b0, 1'b0);

    ws = '{8, 8, 8};
    run_frame(ws, 2, 1'b0, 1'b1, 1'b1, -1);
    ws = '{8, 8, 6};
    run_frame(ws, 1, 1'b0, 1'b0, 1'b1, -1);
    clear_errs();
    ws = '{5, 5, 5};
    run_frame(ws, 3, 1'b1, 1'b1, 1'b1, -1);
    ws = '{4, 4};
    run_frame(ws, 0, 1'b0, 1'b1, 1'b1, -1);
    ws = '{20, 20, 16};
    run_frame(ws, 1, 1'b0, 1'b0, 1'b1, -1);
    clear_errs();
    ws = '{16};
    run_frame(ws, 1, 1'b0, 1'b1, 1'b1, 15);

    // Reset asserted in the middle of a line.
    cfg_sep_case = 1'b1;
    cfg_core_en = 1'b1;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mon_p.x = i;
      mon_p.y = 0;
      mon_p.sep = 1'b1;
      pix_q.push_back(mon_p);
      cyc(1'b1, 1'b1);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset("mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) cyc(1'((k % 4) < 3), 1'b1);
    repeat (3) cyc(1'b0, 1'b0);

    for (int fr = 0; fr < 25; fr++) begin
      ws.delete();
      nl   = 1 + $urandom % 5;
      base = 1 + $urandom % 14;
      for (int l = 0; l < nl; l++) begin
        w = ($urandom % 5 == 0) ? 1 + $urandom % 20 : base;
        ws.push_back(w);
      end
      run_frame(ws, $urandom % 4, 1'($urandom % 2), 1'($urandom % 2),
                ($urandom % 4) != 0, -1);
      if ($urandom % 3 == 0) clear_errs();
    end

    check("pix_queue_drained", pix_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
